// File: rtl/uart_tx_arbiter_if.sv
// uart_tx_arbiter_if: signal bundle between the byte requesters / UART
// transmitter side (master) and the arbiter (slave).
interface uart_tx_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) ();
    logic [NUM_REQ-1:0]   req;
    logic [NUM_REQ*8-1:0] req_data;
    logic                 tx_busy;
    logic [NUM_REQ-1:0]   ack;
    logic [ID_W-1:0]      gnt_id;
    logic [7:0]           p_data;
    logic                 data_valid;
    logic                 arb_busy;

    modport master (
        output req, req_data, tx_busy,
        input  ack, gnt_id, p_data, data_valid, arb_busy
    );

    modport slave (
        input  req, req_data, tx_busy,
        output ack, gnt_id, p_data, data_valid, arb_busy
    );
endinterface

// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: shares one UART transmitter between NUM_REQ byte
// requesters. A grant loads the byte with a one-cycle data_valid, then the
// arbiter follows the transmitter's busy flag through the whole frame; if
// busy never rises within START_TIMEOUT cycles the same byte is re-issued.
// Optional feature macro: UART_ARB_ROUND_ROBIN_EN selects round-robin
// arbitration; without it the lowest requesting index always wins.
module uart_tx_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int ID_W          = 2,
    parameter int START_TIMEOUT = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    uart_tx_arbiter_if.slave bus
);
    localparam logic [1:0] ST_IDLE       = 2'd0;
    localparam logic [1:0] ST_ISSUE      = 2'd1;
    localparam logic [1:0] ST_WAIT_START = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE  = 2'd3;
    localparam int         CNT_W         = 4;

    logic [1:0]         state_reg, state_next;
    logic [CNT_W-1:0]   cnt_reg, cnt_next, cnt_inc;
    logic [7:0]         p_data_reg, p_data_next;
    logic [ID_W-1:0]    gnt_id_reg, gnt_id_next;
    logic [NUM_REQ-1:0] ack_reg, ack_next;
    logic               data_valid_reg;
    logic               arb_busy_reg;

    logic [7:0]         req_byte [NUM_REQ];
    logic [NUM_REQ-1:0] win_onehot;
    logic               win_found;
    logic [ID_W-1:0]    win_id;

    // Unpack the requester bytes and decode the winner into a one-hot ack.
    genvar gi;
    generate
        for (gi = 0; gi < NUM_REQ; gi++) begin : g_req
            assign req_byte[gi]   = bus.req_data[8*gi +: 8];
            assign win_onehot[gi] = win_found && (win_id == ID_W'(gi));
        end
    endgenerate

`ifdef UART_ARB_ROUND_ROBIN_EN
    logic [ID_W-1:0] rr_ptr_reg;
    logic [ID_W-1:0] rr_idx;

    // Rotating search that starts just after the most recent grant.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        rr_idx    = '0;
        for (int off = 1; off <= NUM_REQ; off++) begin
            rr_idx = ID_W'((int'(rr_ptr_reg) + off) % NUM_REQ);
            if (!win_found && bus.req[rr_idx]) begin
                win_found = 1'b1;
                win_id    = rr_idx;
            end
        end
    end

    // Pointer remembers the last grant; it moves only when a grant is made.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_reg <= ID_W'(NUM_REQ - 1);
        end else if (state_reg == ST_IDLE && win_found) begin
            rr_ptr_reg <= win_id;
        end
    end
`else
    // Fixed priority: scanning downwards leaves the lowest requester as winner.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        for (int i = NUM_REQ - 1; i >= 0; i--) begin
            if (bus.req[ID_W'(i)]) begin
                win_found = 1'b1;
                win_id    = ID_W'(i);
            end
        end
    end
`endif

    assign cnt_inc = cnt_reg + 1'b1;

    // Next-state logic; ack is produced only on the idle-to-issue grant, never on a re-issue.
    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        p_data_next = p_data_reg;
        gnt_id_next = gnt_id_reg;
        ack_next    = '0;
        case (state_reg)
            ST_IDLE: begin
                if (win_found) begin
                    state_next  = ST_ISSUE;
                    p_data_next = req_byte[win_id];
                    gnt_id_next = win_id;
                    ack_next    = win_onehot;
                end
            end
            ST_ISSUE: begin
                cnt_next   = '0;
                state_next = ST_WAIT_START;
            end
            ST_WAIT_START: begin
                if (bus.tx_busy) begin
                    state_next = ST_WAIT_DONE;
                end else if (cnt_inc == CNT_W'(START_TIMEOUT)) begin
                    state_next = ST_ISSUE;
                end else begin
                    cnt_next = cnt_inc;
                end
            end
            ST_WAIT_DONE: begin
                if (!bus.tx_busy) begin
                    state_next = ST_IDLE;
                end
            end
            default: state_next = ST_IDLE;
        endcase
    end

    // State and registered outputs; strobes are derived from the next state so they line up with it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= ST_IDLE;
            cnt_reg        <= '0;
            p_data_reg     <= 8'h00;
            gnt_id_reg     <= '0;
            ack_reg        <= '0;
            data_valid_reg <= 1'b0;
            arb_busy_reg   <= 1'b0;
        end else begin
            state_reg      <= state_next;
            cnt_reg        <= cnt_next;
            p_data_reg     <= p_data_next;
            gnt_id_reg     <= gnt_id_next;
            ack_reg        <= ack_next;
            data_valid_reg <= (state_next == ST_ISSUE);
            arb_busy_reg   <= (state_next != ST_IDLE);
        end
    end

    assign bus.ack        = ack_reg;
    assign bus.gnt_id     = gnt_id_reg;
    assign bus.p_data     = p_data_reg;
    assign bus.data_valid = data_valid_reg;
    assign bus.arb_busy   = arb_busy_reg;
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// tb_uart_tx_arbiter: directed tests for uart_tx_arbiter with a frame-level
// transmitter stand-in (even parity, one cycle per bit) and a per-cycle
// reference model of the arbitration rules.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;
    localparam int NUM_REQ       = 4;
    localparam int ID_W          = 2;
    localparam int START_TIMEOUT = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    uart_tx_arbiter_if #(.NUM_REQ(NUM_REQ), .ID_W(ID_W)) ifc ();

    uart_tx_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ID_W(ID_W),
        .START_TIMEOUT(START_TIMEOUT)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .bus(ifc.slave)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- transmitter stand-in ----------------
    logic        tx_auto   = 1'b1;
    logic        tx_manual = 1'b0;
    logic        tx_busy_m;
    logic [10:0] tx_frame;
    int          tx_bits;
    logic        tx_out;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy_m <= 1'b0;
            tx_frame  <= '1;
            tx_bits   <= 0;
        end else if (tx_busy_m) begin
            if (tx_bits == 10) tx_busy_m <= 1'b0;
            else tx_bits <= tx_bits + 1;
            tx_frame <= {1'b1, tx_frame[10:1]};
        end else if (tx_auto && ifc.data_valid) begin
            tx_busy_m <= 1'b1;
            tx_bits   <= 0;
            tx_frame  <= {1'b1, ^ifc.p_data, ifc.p_data, 1'b0};
        end
    end
    assign tx_out      = tx_busy_m ? tx_frame[0] : 1'b1;
    assign ifc.tx_busy = tx_auto ? tx_busy_m : tx_manual;

    // ---------------- reference model ----------------
    logic [NUM_REQ-1:0]   snap_req  = '0;
    logic [NUM_REQ*8-1:0] snap_data = '0;
    logic                 snap_busy = 1'b0;
    logic                 snap_rst  = 1'b0;

    always @(posedge clk) begin
        snap_req  <= ifc.req;
        snap_data <= ifc.req_data;
        snap_busy <= ifc.tx_busy;
        snap_rst  <= rst_n;
    end

    bit                 m_engaged, m_started, m_dv, m_was;
    int                 m_age, m_w;
    logic [ID_W-1:0]    m_id, m_last;
    logic [7:0]         m_data;
    logic [NUM_REQ-1:0] m_ack;

    function automatic int pick(logic [NUM_REQ-1:0] r, int last);
`ifdef UART_ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= NUM_REQ; k++)
            if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
`else
        for (int k = 0; k < NUM_REQ; k++)
            if (r[k]) return k + 0 * last;
`endif
        return -1;
    endfunction

    // Advance the model by the edge that just passed, then compare outputs.
    always @(negedge clk) begin
        if (!rst_n || !snap_rst) begin
            m_engaged = 0; m_started = 0; m_dv = 0; m_age = 0;
            m_id = '0; m_data = 8'h00; m_ack = '0; m_last = ID_W'(NUM_REQ - 1);
        end else begin
            m_ack = '0;
            m_was = m_dv;
            m_dv  = 0;
            if (!m_engaged) begin
                m_w = pick(snap_req, int'(m_last));
                if (m_w >= 0) begin
                    m_engaged = 1; m_started = 0; m_age = 0;
                    m_id = ID_W'(m_w); m_last = ID_W'(m_w);
                    m_data = snap_data[8*m_w +: 8];
                    m_dv = 1; m_ack[m_w] = 1'b1;
                end
            end else if (!m_started) begin
                if (!m_was) begin
                    if (snap_busy) m_started = 1;
                    else begin
                        m_age++;
                        if (m_age == START_TIMEOUT) begin
                            m_dv  = 1;
                            m_age = 0;
                        end
                    end
                end
            end else if (!snap_busy) begin
                m_engaged = 0;
            end
        end
        n_tests++;
        if (ifc.data_valid !== m_dv || ifc.ack !== m_ack || ifc.gnt_id !== m_id ||
            ifc.p_data !== m_data || ifc.arb_busy !== m_engaged) begin
            n_fail++;
            $display("FAIL cycle_model t=%0t got dv=%b ack=%b id=%0d pd=%h busy=%b required dv=%b ack=%b id=%0d pd=%h busy=%b",
                     $time, ifc.data_valid, ifc.ack, ifc.gnt_id, ifc.p_data, ifc.arb_busy,
                     m_dv, m_ack, m_id, m_data, m_engaged);
        end
    end

    // ---------------- helpers ----------------
    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h required %0h", name, got, exp);
        end else begin
            $display("[TB] ok %s = %0h", name, got);
        end
    endtask

    task automatic wait_dv(input string name);
        bit seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            @(negedge clk);
            if (ifc.data_valid === 1'b1) seen = 1;
        end
        check({name, "_dv_seen"}, 32'(seen), 32'd1);
    endtask

    task automatic wait_idle(input string name);
        bit idle = 0;
        for (int i = 0; i < 80 && !idle; i++) begin
            @(negedge clk);
            if (ifc.arb_busy === 1'b0 && ifc.tx_busy === 1'b0) idle = 1;
        end
        check({name, "_idle"}, 32'(idle), 32'd1);
    endtask

    task automatic wait_tx_busy(input string name);
        bit seen = 0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk);
            if (ifc.tx_busy === 1'b1) seen = 1;
        end
        check({name, "_tx_busy"}, 32'(seen), 32'd1);
    endtask

    // ---------------- stimulus ----------------
    logic [10:0]        rec;
    int                 nrec, pulses, extra_ack, dv_before;
    int                 pulse_at [3];
    logic [NUM_REQ-1:0] ack_s;
    bit                 fell;

    initial begin
        ifc.req = '0;
        ifc.req_data = '0;

        // Reset values
        @(negedge clk);
        check("rst_p_data", 32'(ifc.p_data), 32'h00);
        check("rst_dv", 32'(ifc.data_valid), 32'd0);
        check("rst_ack", 32'(ifc.ack), 32'd0);
        check("rst_gnt_id", 32'(ifc.gnt_id), 32'd0);
        check("rst_arb_busy", 32'(ifc.arb_busy), 32'd0);
        @(negedge clk); #2 rst_n = 1'b1;

        // Single request from requester 2, byte 0x2A, with frame capture
        @(posedge clk); #1;
        ifc.req_data = 32'h002A_0000;
        ifc.req = 4'b0100;
        wait_dv("single");
        check("single_p_data", 32'(ifc.p_data), 32'h2A);
        check("single_ack", 32'(ifc.ack), 32'b0100);
        check("single_gnt_id", 32'(ifc.gnt_id), 32'd2);
        @(posedge clk); #1 ifc.req = '0;
        rec = '0; nrec = 0; fell = 0;
        for (int i = 0; i < 30 && !fell; i++) begin
            @(negedge clk);
            if (tx_busy_m) begin
                rec = {tx_out, rec[10:1]};
                nrec++;
            end else if (nrec > 0) begin
                fell = 1;
            end
        end
        check("frame_len", 32'(nrec), 32'd11);
        check("frame_bits_2A", 32'(rec), 32'b110_0101_0100);
        check("arb_busy_when_tx_falls", 32'(ifc.arb_busy), 32'd1);
        @(negedge clk);
        check("arb_busy_one_cycle_later", 32'(ifc.arb_busy), 32'd0);
        wait_idle("single");

        // All four requesting
        @(negedge clk); #2 rst_n = 1'b0;
        @(negedge clk); #2 rst_n = 1'b1;
        @(posedge clk); #1;
        ifc.req_data = 32'h1312_1110;
        ifc.req = 4'b1111;
`ifdef UART_ARB_ROUND_ROBIN_EN
        for (int g = 0; g < 4; g++) begin
            wait_dv("rr");
            check($sformatf("rr_order_%0d", g), 32'(ifc.p_data), 32'h10 + 32'(g));
            check($sformatf("rr_ack_%0d", g), 32'(ifc.ack), 32'(4'b0001 << g));
            ack_s = ifc.ack;
            @(posedge clk); #1 ifc.req = ifc.req & ~ack_s;
        end
`else
        for (int g = 0; g < 3; g++) begin
            wait_dv("fp");
            check($sformatf("fp_p_data_%0d", g), 32'(ifc.p_data), 32'h10);
            check($sformatf("fp_gnt_id_%0d", g), 32'(ifc.gnt_id), 32'd0);
        end
        @(posedge clk); #1 ifc.req = '0;
`endif
        wait_idle("all4");

        // Start timeout: transmitter never goes busy
        tx_auto = 1'b0;
        tx_manual = 1'b0;
        @(posedge clk); #1;
        ifc.req_data = 32'h0000_0055;
        ifc.req = 4'b0001;
        wait_dv("timeout");
        check("timeout_first_ack", 32'(ifc.ack), 32'b0001);
        @(posedge clk); #1 ifc.req = '0;
        pulses = 0; extra_ack = 0;
        for (int i = 1; i <= 16; i++) begin
            @(negedge clk);
            if (ifc.ack !== '0) extra_ack++;
            if (ifc.data_valid === 1'b1) begin
                if (pulses < 3) pulse_at[pulses] = i;
                pulses++;
                check($sformatf("timeout_p_data_%0d", i), 32'(ifc.p_data), 32'h55);
            end
        end
        check("timeout_pulses", 32'(pulses), 32'd3);
        check("timeout_pulse1_at", 32'(pulse_at[0]), 32'd5);
        check("timeout_pulse2_at", 32'(pulse_at[1]), 32'd10);
        check("timeout_pulse3_at", 32'(pulse_at[2]), 32'd15);
        check("timeout_extra_ack", 32'(extra_ack), 32'd0);
        @(posedge clk); #1 tx_manual = 1'b1;
        repeat (3) @(posedge clk);
        #1 tx_manual = 1'b0;
        wait_idle("timeout");
        tx_auto = 1'b1;

        // New request arriving mid-frame
        @(posedge clk); #1;
        ifc.req_data = 32'h3300_0044;
        ifc.req = 4'b0001;
        wait_dv("mid_first");
        check("mid_first_gnt", 32'(ifc.gnt_id), 32'd0);
        @(posedge clk); #1 ifc.req = '0;
        wait_tx_busy("mid");
        @(posedge clk); #1 ifc.req = 4'b1000;
        dv_before = 0; fell = 0;
        for (int i = 0; i < 30 && !fell; i++) begin
            @(negedge clk);
            if (ifc.data_valid === 1'b1) dv_before++;
            if (ifc.tx_busy === 1'b0) fell = 1;
        end
        check("mid_tx_fell", 32'(fell), 32'd1);
        check("mid_no_dv_during_frame", 32'(dv_before), 32'd0);
        @(negedge clk);
        check("mid_idle_gap_dv", 32'(ifc.data_valid), 32'd0);
        @(negedge clk);
        check("mid_grant_dv", 32'(ifc.data_valid), 32'd1);
        check("mid_grant_id", 32'(ifc.gnt_id), 32'd3);
        check("mid_grant_ack", 32'(ifc.ack), 32'b1000);
        check("mid_grant_p_data", 32'(ifc.p_data), 32'h33);
        @(posedge clk); #1 ifc.req = '0;
        wait_idle("mid");

        // Reset in the middle of a frame
        @(posedge clk); #1;
        ifc.req_data = 32'h0077_6600;
        ifc.req = 4'b0100;
        wait_dv("rstmid");
        @(posedge clk); #1 ifc.req = 4'b0010;
        wait_tx_busy("rstmid");
        @(negedge clk); #2 rst_n = 1'b0;
        #1;
        check("rstmid_p_data", 32'(ifc.p_data), 32'h00);
        check("rstmid_dv", 32'(ifc.data_valid), 32'd0);
        check("rstmid_ack", 32'(ifc.ack), 32'd0);
        check("rstmid_gnt_id", 32'(ifc.gnt_id), 32'd0);
        check("rstmid_arb_busy", 32'(ifc.arb_busy), 32'd0);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        wait_dv("rstmid_after");
        check("rstmid_after_gnt", 32'(ifc.gnt_id), 32'd1);
        check("rstmid_after_p_data", 32'(ifc.p_data), 32'h66);
        check("rstmid_after_ack", 32'(ifc.ack), 32'b0010);
        @(posedge clk); #1 ifc.req = '0;
        wait_idle("rstmid");

        repeat (2) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete (got timeout, required finish)");
        $fatal(1, "watchdog");
    end
endmodule
